// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared IEEE-754 single-precision field, constant and class definitions
// Purpose: common definitions for the FP multiplier and divider.
// Ports: none (package).
package fp_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  localparam int          FP_BIAS    = 127;
  localparam logic [7:0]  FP_EXP_MAX = 8'hFF;
  localparam logic [31:0] FP_QNAN    = 32'h7FC00000;

  typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} fp_class_t;

  // exp==0 is treated as zero: denormal inputs are flushed.
  function automatic fp_class_t fp_classify(input fp32_t x);
    fp_class_t c;
    if (x.exp == 8'h00)
      c = ZERO;
    else if (x.exp == FP_EXP_MAX)
      c = (x.frac == 23'b0) ? INF : NAN;
    else
      c = NORMAL;
    return c;
  endfunction

endpackage

// File: rtl/unsigned_mul.sv
// rtl/unsigned_mul.sv - iterative 24x24->48 unsigned shift-add multiplier core
// Purpose: retires RADIX_LOG2 multiplier bits per cycle into a 48b accumulator.
// Ports:
//   clk, rst  clock, async active-high reset
//   start     load A/B and clear the accumulator (ignored while busy is handled by the caller)
//   A, B      24b multiplicand / multiplier
//   busy      iteration in progress
//   done      high in the cycle whose closing edge retires the last bits
//   P         48b product, valid once busy falls; held until the next start
module unsigned_mul #(
  parameter int RADIX_LOG2 = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] A,
  input  logic [23:0] B,
  output logic        busy,
  output logic        done,
  output logic [47:0] P
);

  // RADIX_LOG2 bits are retired per cycle, so 24/RADIX_LOG2 cycles in total.
  localparam logic [4:0] MULT_CYCLES = 5'(24 / RADIX_LOG2);

  logic [47:0] acc_q, acc_d;
  logic [47:0] a_q, a_d;
  logic [23:0] b_q, b_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [47:0] sum;

  always_comb begin
    sum = acc_q;
    for (int j = 0; j < RADIX_LOG2; j++)
      if (b_q[j]) sum = sum + (a_q << j);
  end

  always_comb begin
    acc_d  = acc_q;
    a_d    = a_q;
    b_d    = b_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start) begin
      acc_d  = '0;
      a_d    = {24'b0, A};
      b_d    = B;
      cnt_d  = MULT_CYCLES;
      busy_d = 1'b1;
    end else if (busy_q) begin
      acc_d  = sum;
      a_d    = a_q << RADIX_LOG2;
      b_d    = b_q >> RADIX_LOG2;
      cnt_d  = cnt_q - 5'd1;
      busy_d = (cnt_q != 5'd1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      a_q    <= a_d;
      b_q    <= b_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;
  // Asserted one cycle early so the top leaves MULT on the same edge the product completes.
  assign done = busy_q & (cnt_q == 5'd1);
  assign P    = acc_q;

endmodule

// File: rtl/fp_mul_seq.sv
// rtl/fp_mul_seq.sv - sequential IEEE-754 single-precision multiplier
// Purpose: valid/ready operand intake, iterative mantissa product, normalise, round, range/special handling.
// Ports:
//   clk, rst                  clock, async active-high reset
//   in_valid, in_ready        operand handshake (in_ready high only in IDLE)
//   num1, num2                IEEE-754 single operands
//   out_valid, out_ready      result handshake (result held until out_ready)
//   S                         IEEE-754 single product
//   overflow/underflow/invalid mutually exclusive result flags
module fp_mul_seq
  import fp_pkg::*;
#(
  parameter int RADIX_LOG2 = 1,
  parameter int ROUND_EN   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] num1,
  input  logic [31:0] num2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] S,
  output logic        overflow,
  output logic        underflow,
  output logic        invalid
);

  typedef enum logic [2:0] {IDLE, MULT, NORM, ROUND, DONE} state_t;

  state_t             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               sign_q, sign_d;
  logic signed [9:0]  exp_q, exp_d;
  fp_class_t          cls_q, cls_d;
  logic [22:0]        frac_q, frac_d;
  logic               guard_q, guard_d;
  logic               sticky_q, sticky_d;
  logic [31:0]        s_q, s_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic               inv_q, inv_d;

  fp32_t              a, b;
  fp_class_t          ca, cb;
  logic               accept;
  logic               mul_busy, mul_done;
  logic [47:0]        prod;
  logic               round_inc;
  logic [23:0]        rnd_sum;
  logic [22:0]        frac_r;
  logic signed [9:0]  exp_r;

  assign a      = num1;
  assign b      = num2;
  assign ca     = fp_classify(a);
  assign cb     = fp_classify(b);
  assign accept = in_valid & in_ready_q & ~mul_busy;

  unsigned_mul #(.RADIX_LOG2(RADIX_LOG2)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (accept),
    .A     ({1'b1, a.frac}),
    .B     ({1'b1, b.frac}),
    .busy  (mul_busy),
    .done  (mul_done),
    .P     (prod)
  );

  // Round only the stored fraction; a carry out means the mantissa became 2.0 -> 1.0 with e+1.
  always_comb begin
    round_inc = (ROUND_EN != 0) && guard_q && (sticky_q || frac_q[0]);
    rnd_sum   = {1'b0, frac_q} + {23'b0, round_inc};
    frac_r    = rnd_sum[22:0];
    exp_r     = rnd_sum[23] ? exp_q + 10'sd1 : exp_q;
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    cls_d       = cls_q;
    frac_d      = frac_q;
    guard_d     = guard_q;
    sticky_d    = sticky_q;
    s_d         = s_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    inv_d       = inv_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          sign_d = a.sign ^ b.sign;
          exp_d  = 10'($signed({2'b00, a.exp}) + $signed({2'b00, b.exp}) - FP_BIAS);
          if (ca == NAN || cb == NAN || (ca == INF && cb == ZERO) || (ca == ZERO && cb == INF))
            cls_d = NAN;
          else if (ca == INF || cb == INF)
            cls_d = INF;
          else if (ca == ZERO || cb == ZERO)
            cls_d = ZERO;
          else
            cls_d = NORMAL;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          inv_d   = 1'b0;
          state_d = MULT;
        end
      end
      MULT: begin
        if (mul_done) state_d = NORM;
      end
      NORM: begin
        // Product lies in [1,4); the hidden bit is dropped from the stored fraction.
        if (prod[47]) begin
          frac_d   = prod[46:24];
          guard_d  = prod[23];
          sticky_d = |prod[22:0];
          exp_d    = exp_q + 10'sd1;
        end else begin
          frac_d   = prod[45:23];
          guard_d  = prod[22];
          sticky_d = |prod[21:0];
        end
        state_d = ROUND;
      end
      ROUND: begin
        out_valid_d = 1'b1;
        state_d     = DONE;
        case (cls_q)
          NAN: begin
            s_d   = FP_QNAN;
            inv_d = 1'b1;
          end
          INF:  s_d = {sign_q, FP_EXP_MAX, 23'b0};
          ZERO: s_d = {sign_q, 31'b0};
          default: begin
            if (exp_r >= 10'sd255) begin
              s_d   = {sign_q, FP_EXP_MAX, 23'b0};
              ovf_d = 1'b1;
            end else if (exp_r <= 10'sd0) begin
              s_d   = {sign_q, 31'b0};
              unf_d = 1'b1;
            end else begin
              s_d = {sign_q, exp_r[7:0], frac_r};
            end
          end
        endcase
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      cls_q       <= ZERO;
      frac_q      <= '0;
      guard_q     <= 1'b0;
      sticky_q    <= 1'b0;
      s_q         <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      inv_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      cls_q       <= cls_d;
      frac_q      <= frac_d;
      guard_q     <= guard_d;
      sticky_q    <= sticky_d;
      s_q         <= s_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      inv_q       <= inv_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign S         = s_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign invalid   = inv_q;

endmodule

// File: tb/tb_fp_mul_seq.sv
// tb/tb_fp_mul_seq.sv - self-checking bench for fp_mul_seq
module tb_fp_mul_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] num1;
  logic [31:0] num2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] S;
  logic        overflow;
  logic        underflow;
  logic        invalid;

  fp_mul_seq #(.RADIX_LOG2(1), .ROUND_EN(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .num1      (num1),
    .num2      (num2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .overflow  (overflow),
    .underflow (underflow),
    .invalid   (invalid)
  );

  always #5 clk = ~clk;

  localparam int LAT = 26;
  localparam int NV  = 12;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] s;
    logic [2:0]  f;   // {overflow, underflow, invalid}
  } vec_t;

  vec_t vecs [NV];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    num1     = a;
    num2     = b;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(inout int lat);
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    vecs[0]  = '{32'h40400000, 32'h40200000, 32'h40F00000, 3'b000};
    vecs[1]  = '{32'hBFC00000, 32'h3FC00000, 32'hC0100000, 3'b000};
    vecs[2]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 3'b000};
    vecs[3]  = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 3'b000};
    vecs[4]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b001};
    vecs[5]  = '{32'h7F800000, 32'hC0000000, 32'hFF800000, 3'b000};
    vecs[6]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b001};
    vecs[7]  = '{32'h7F000000, 32'h40000000, 32'h7F800000, 3'b100};
    vecs[8]  = '{32'h00800000, 32'h3F000000, 32'h00000000, 3'b010};
    vecs[9]  = '{32'h00000001, 32'h40000000, 32'h00000000, 3'b000};
    vecs[10] = '{32'h80000000, 32'h3F800000, 32'h80000000, 3'b000};
    vecs[11] = '{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 3'b000};

    clk = 1'b0; rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    num1 = '0; num2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_S",         S,                  32'd0);
    chk("rst_flags",     {29'b0, overflow, underflow, invalid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      start_op(vecs[i].a, vecs[i].b);
      lat = 0;
      wait_valid(lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(LAT));
      chk($sformatf("v%0d_S", i), S, vecs[i].s);
      chk($sformatf("v%0d_flags", i), {29'b0, overflow, underflow, invalid}, {29'b0, vecs[i].f});
      handshake();
    end

    // in_valid pulses while multiplying must not disturb the operation in flight
    start_op(32'h40400000, 32'h40200000);
    lat = 0;
    repeat (3) begin @(posedge clk); @(negedge clk); lat++; end
    num1 = 32'h7F800000; num2 = 32'h00000000; in_valid = 1'b1;
    chk("busy_in_ready", {31'b0, in_ready}, 32'd0);
    repeat (2) begin @(posedge clk); @(negedge clk); lat++; end
    in_valid = 1'b0;
    wait_valid(lat);
    chk("ignore_latency", 32'(lat), 32'(LAT));
    chk("ignore_S", S, 32'h40F00000);
    chk("ignore_flags", {29'b0, overflow, underflow, invalid}, 32'd0);
    handshake();

    // result held while out_ready stays low
    start_op(32'hBFC00000, 32'h3FC00000);
    lat = 0;
    wait_valid(lat);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("hold%0d_out_valid", c), {31'b0, out_valid}, 32'd1);
      chk($sformatf("hold%0d_S", c), S, 32'hC0100000);
      chk($sformatf("hold%0d_in_ready", c), {31'b0, in_ready}, 32'd0);
    end
    handshake();
    chk("release_out_valid", {31'b0, out_valid}, 32'd0);
    chk("release_in_ready",  {31'b0, in_ready},  32'd1);

    // asynchronous reset in the middle of MULT
    start_op(32'h7F000000, 32'h40000000);
    repeat (10) begin @(posedge clk); @(negedge clk); end
    chk("midmult_in_ready", {31'b0, in_ready}, 32'd0);
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("async_rst_in_ready",  {31'b0, in_ready},  32'd1);
    chk("async_rst_S",         S,                  32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_op(32'h40400000, 32'h40200000);
    lat = 0;
    wait_valid(lat);
    chk("post_rst_latency", 32'(lat), 32'(LAT));
    chk("post_rst_S", S, 32'h40F00000);
    chk("post_rst_flags", {29'b0, overflow, underflow, invalid}, 32'd0);
    handshake();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
